pop_count_arbiter: RTL and testbench
====================================

Name: pop_count_arbiter

Overview:
Shares one registered 32-bit population-count datapath between NREQ requesters. Round-robin arbitration selects one request word per cycle and registers it into the operand stage. The combinational popcount result is registered into the result stage and returned on a single tagged response channel with valid/ready backpressure. Sits between client blocks and the popcount core, replacing the plain Fmax in/out register wrapper.

Parameters:
NREQ, 4, number of requesters (2..16)
ID_W, $clog2(NREQ) (localparam), width of requester tag

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_data  input  NREQ*32  flattened words; requester i occupies bits [32*i+31:32*i]
req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
rsp_valid  output  1  response valid
rsp_id  output  ID_W  index of the requester that owns the response
rsp_count  output  6  popcount of the accepted word, 0..32
rsp_ready  input  1  response consumer accept
op_count  output  32  accepted-request counter (only with POP_CNT_STATS_EN)

Behaviour:
- Reset: rst high clears all state asynchronously. rsp_valid=0, rsp_id=0, rsp_count=0, operand stage invalid, RR pointer=0, op_count=0. req_ready is 0 while rst is high.
- Pipeline has two register stages. S1 (operand) holds v1, data1[31:0] and id1. S2 (result) holds rsp_valid, rsp_id and rsp_count. rsp_count = popcount(data1), computed combinationally between S1 and S2.
- Stall logic:
  - s2_free = !rsp_valid | rsp_ready
  - s1_free = !v1 | s2_free
- Arbitration:
  - Runs when s1_free.
  - grant is the first i with req_valid[i], searching from ptr and wrapping modulo NREQ.
  - req_ready[grant]=1. All other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid and rsp_ready.
  - If !s1_free, all req_ready bits are 0.
- Handshake: req_valid[i]&req_ready[i] at an edge loads S1 with req_data[i] and id i, and sets ptr=(i+1) mod NREQ. Without a grant, ptr holds.
- Once asserted, req_valid must hold with stable data until accepted. The arbiter never drops an asserted request.
- S2 loads from S1 when s2_free: rsp_valid<=v1, and count/id are captured.
- When s2_free and no grant, S1 sets v1<=0.
- Latency: request accepted at edge N gives its response visible after edge N+1. That is 2 edges from request presentation to first response visibility, with no stall.
- Throughput: 1 word per cycle with rsp_ready held high.
- Backpressure: while rsp_valid & !rsp_ready, S2 holds rsp_id/rsp_count stable. S1 holds if valid. The arbiter accepts at most one more word, into an empty S1.
- Ordering: responses leave in acceptance order. No reordering and no loss.
- Simultaneous events: an S2 drain and an S1 refill in the same edge are both legal and required.
- Boundaries: data 0 gives count 0. Data 0xFFFFFFFF gives count 32 (6-bit, no overflow).
- Reset mid-operation: in-flight S1/S2 contents are discarded and no response is emitted. Requesters must re-present their requests.

Optional Feature:
POP_CNT_STATS_EN:
- Defined: port op_count exists. It increments by 1 on every accepted request, wraps 0xFFFFFFFF to 0, and resets to 0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package pop_count_pkg holds:
  - POP_DATA_W=32
  - POP_CNT_W=6
  - the response struct typedef {id, count}
- Sub-module rr_arbiter (NREQ): inputs req, ptr and enable; outputs a one-hot grant and the grant index. The pointer register stays in pop_count_arbiter.
- The popcount function is the existing LUT8 popcount core, instantiated between S1 and S2.

Test Plan:
1. Single request: requester 2 presents 0x0000000F, rsp_ready=1 -> req_ready[2] high that cycle; after 2 edges rsp_valid=1, rsp_id=2, rsp_count=4 for 1 cycle.
2. Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1,... Response ids follow the same sequence, one per cycle.
3. Extremes: data 0x00000000 gives count 0, 0xFFFFFFFF gives count 32, 0xAAAAAAAA gives count 16; all with correct ids, back-to-back.
4. Backpressure: rsp_ready=0 for 5 cycles with all requesters valid.
   - rsp_id/rsp_count stay stable.
   - Exactly one further word is accepted, then all req_ready=0.
   - On rsp_ready=1, responses drain in order with no loss or duplication.
5. Reset mid-flight: assert rst while S1 and S2 are valid -> rsp_valid=0 immediately (asynchronous), ptr=0, and no stale response after rst deasserts.
6. With POP_CNT_STATS_EN: 10 accepted requests -> op_count=10. Preload near 0xFFFFFFFF via force and check wrap to 0.

Source files
------------

// File: rtl/pop_count_pkg.sv
// Shared definitions for the pop_count_arbiter slice.
// Optional feature macro: POP_CNT_STATS_EN (see pop_count_arbiter.sv).
package pop_count_pkg;

    localparam int unsigned POP_DATA_W = 32;
    localparam int unsigned POP_CNT_W  = 6;
    // Widest tag needed for the largest supported NREQ (16).
    localparam int unsigned POP_ID_W   = 4;

    typedef struct packed {
        logic [POP_ID_W-1:0]  id;
        logic [POP_CNT_W-1:0] count;
    } pop_rsp_t;

endpackage

// File: rtl/pop_count_arbiter_core.sv
// LUT8 popcount core: four byte-wide counts summed into a 6-bit result.
module pop_count_core
    import pop_count_pkg::*;
(
    input  logic [POP_DATA_W-1:0] data,
    output logic [POP_CNT_W-1:0]  count
);

    function automatic logic [3:0] pop8(input logic [7:0] b);
        logic [3:0] s;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            s = s + {3'b000, b[i]};
        end
        return s;
    endfunction

    // Sum of per-byte counts; max 32 fits in 6 bits.
    always_comb begin
        count = {2'b00, pop8(data[7:0])}   + {2'b00, pop8(data[15:8])}
              + {2'b00, pop8(data[23:16])} + {2'b00, pop8(data[31:24])};
    end

endmodule

// File: rtl/pop_count_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr, wrapping modulo NREQ.
// The pointer register is owned by the instantiating module.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic found;
    int unsigned idx;

    // First requester at or after ptr wins; nothing is granted when disabled.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req[ID_W'(idx)]) begin
                found     = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
        if (found && enable) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/pop_count_arbiter.sv
// Round-robin shared popcount datapath: NREQ requesters -> S1 operand -> S2 result.
// Optional feature macro: POP_CNT_STATS_EN adds the op_count accepted-request counter.
module pop_count_arbiter
    import pop_count_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*POP_DATA_W-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [POP_CNT_W-1:0]       rsp_count,
    input  logic                       rsp_ready
`ifdef POP_CNT_STATS_EN
    ,
    output logic [31:0]                op_count
`endif
);

    logic                  v1;
    logic [POP_DATA_W-1:0] data1;
    logic [ID_W-1:0]       id1;
    logic [ID_W-1:0]       ptr;
    pop_rsp_t              s2;
    logic                  s2_free;
    logic                  s1_free;
    logic                  arb_en;
    logic [NREQ-1:0]       grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  accept;
    logic [POP_DATA_W-1:0] data_sel;
    logic [POP_CNT_W-1:0]  count1;
    logic                  unused_id_hi;

    // Stall chain: S2 frees when empty or draining, S1 frees when empty or S2 frees.
    always_comb begin
        s2_free = !rsp_valid || rsp_ready;
        s1_free = !v1 || s2_free;
        arb_en  = s1_free && !rst;
        accept  = |grant;
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // One-hot mux of the granted request word.
    always_comb begin
        data_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                data_sel = data_sel | req_data[i*POP_DATA_W +: POP_DATA_W];
            end
        end
    end

    pop_count_core u_core (
        .data  (data1),
        .count (count1)
    );

    // S1 operand stage and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            data1 <= '0;
            id1   <= '0;
            ptr   <= '0;
        end else begin
            if (accept) begin
                v1    <= 1'b1;
                data1 <= data_sel;
                id1   <= grant_idx;
                if (grant_idx == ID_W'(NREQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_idx + 1'b1;
                end
            end else if (s2_free) begin
                v1 <= 1'b0;
            end
        end
    end

    // S2 result stage: loads whenever it is free, holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            s2        <= '0;
        end else if (s2_free) begin
            rsp_valid <= v1;
            s2.id     <= POP_ID_W'(id1);
            s2.count  <= count1;
        end
    end

    assign req_ready    = grant;
    assign rsp_id       = s2.id[ID_W-1:0];
    assign rsp_count    = s2.count;
    assign unused_id_hi = ^s2.id;

`ifdef POP_CNT_STATS_EN
    logic [31:0] op_cnt_q;

    // Accepted-request counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt_q <= '0;
        end else if (accept) begin
            op_cnt_q <= op_cnt_q + 32'd1;
        end
    end

    assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_pop_count_arbiter.sv
// Directed bench for pop_count_arbiter (NREQ=4); covers POP_CNT_STATS_EN when defined.
module tb_pop_count_arbiter;

    localparam int NREQ = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [5:0]       rsp_count;
    logic             rsp_ready;
`ifdef POP_CNT_STATS_EN
    logic [31:0]      op_count;
`endif

    always #5 clk = ~clk;

    pop_count_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_ready (rsp_ready)
`ifdef POP_CNT_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Hand-computed expected count for each requester's current word.
    logic [5:0] exp_cnt [NREQ];

    typedef struct {
        int unsigned id;
        logic [5:0]  cnt;
    } sb_t;
    sb_t         sbq[$];
    int unsigned gl[$];
    int          rsp_seen = 0;

    typedef struct {
        int unsigned id;
        logic [31:0] data;
        logic [5:0]  cnt;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int unsigned id, input logic [31:0] d, input logic [5:0] c);
        req_data[id*32 +: 32] = d;
        exp_cnt[id] = c;
    endtask

    task automatic default_words();
        set_word(0, 32'h0000_0000, 6'd0);
        set_word(1, 32'hFFFF_FFFF, 6'd32);
        set_word(2, 32'hAAAA_AAAA, 6'd16);
        set_word(3, 32'h0F0F_0F0F, 6'd16);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        gl.delete();
    endtask

    // Scoreboard: log grants and pair every response with the oldest accept.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if ($countones(req_ready) > 1) begin
                chk("onehot_ready", 32'(req_ready), 32'h0);
            end
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual_id=%0d required=no_response", rsp_id);
                end else begin
                    chk("sb_id", 32'(rsp_id), 32'(sbq[0].id));
                    chk("sb_count", 32'(rsp_count), 32'(sbq[0].cnt));
                    void'(sbq.pop_front());
                end
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sbq.push_back('{id: i, cnt: exp_cnt[i]});
                    gl.push_back(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned n0;

        vecs[0] = '{id: 2, data: 32'h0000_000F, cnt: 6'd4};
        vecs[1] = '{id: 0, data: 32'h0000_0000, cnt: 6'd0};
        vecs[2] = '{id: 1, data: 32'hFFFF_FFFF, cnt: 6'd32};
        vecs[3] = '{id: 3, data: 32'hAAAA_AAAA, cnt: 6'd16};
        vecs[4] = '{id: 0, data: 32'h8000_0001, cnt: 6'd2};
        vecs[5] = '{id: 3, data: 32'h1234_5678, cnt: 6'd13};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        default_words();
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_count", 32'(rsp_count), 32'h0);
`ifdef POP_CNT_STATS_EN
        chk("rst_op_count", op_count, 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requests: grant same cycle, response after two edges, one cycle wide.
        foreach (vecs[k]) begin
            set_word(vecs[k].id, vecs[k].data, vecs[k].cnt);
            req_valid = '0;
            req_valid[vecs[k].id] = 1'b1;
            #1;
            chk("vec_ready", 32'(req_ready), 32'(1 << vecs[k].id));
            step();
            req_valid = '0;
            chk("vec_lat1_valid", 32'(rsp_valid), 32'h0);
            step();
            chk("vec_valid", 32'(rsp_valid), 32'h1);
            chk("vec_id", 32'(rsp_id), vecs[k].id);
            chk("vec_count", 32'(rsp_count), 32'(vecs[k].cnt));
            step();
            chk("vec_valid_pulse", 32'(rsp_valid), 32'h0);
        end
        default_words();

        // Round-robin with all requesters valid, back-to-back extremes.
        do_reset();
        rsp_seen  = 0;
        req_valid = '1;
        repeat (8) @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) step();
        chk("rr_grants", gl.size(), 32'd8);
        for (int unsigned k = 0; k < gl.size(); k++) begin
            chk("rr_order", gl[k], k % NREQ);
        end
        chk("rr_rsp_seen", rsp_seen, 32'd8);
        chk("rr_drained", sbq.size(), 32'd0);

        // Reset with S1 and S2 both occupied.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #2;
        chk("mid_pre_valid", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        gl.delete();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mid_no_stale", 32'(rsp_valid), 32'h0);
        end
        req_valid = '1;
        #1;
        chk("mid_ptr_zero", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        repeat (3) step();
        chk("mid_drained", sbq.size(), 32'd0);

        // Backpressure: S2 stalled holding id1, exactly one word into empty S1.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("bp_first_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        step();
        chk("bp_s2_valid", 32'(rsp_valid), 32'h1);
        req_valid = '1;
        #1;
        chk("bp_one_more", 32'(req_ready), 32'h4);
        n0 = gl.size();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready_zero", 32'(req_ready), 32'h0);
            chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold_id", 32'(rsp_id), 32'h1);
            chk("bp_hold_count", 32'(rsp_count), 32'd32);
            step();
        end
        chk("bp_accepts", gl.size(), n0 + 1);
        rsp_ready = 1'b1;
        repeat (6) step();
        req_valid = '0;
        repeat (4) step();
        chk("bp_drained", sbq.size(), 32'd0);
        for (int unsigned k = 0; k < gl.size(); k++) begin
            chk("bp_order", gl[k], (k + 1) % NREQ);
        end

`ifdef POP_CNT_STATS_EN
        // Accepted-request counter and its wrap.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = '1;
        repeat (10) @(posedge clk);
        #1;
        req_valid = '0;
        chk("stats_ten", op_count, 32'd10);
        force dut.op_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.op_cnt_q;
        chk("stats_preload", op_count, 32'hFFFF_FFFE);
        req_valid = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        chk("stats_wrap", op_count, 32'h0);
        repeat (3) step();
        chk("stats_drained", sbq.size(), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
